// File: rtl/spi_reg_pkg.sv
// Shared constants, FSM encoding and frame packing for the SPI register master.
package spi_reg_pkg;

    localparam int FRAME_BITS = 16;
    localparam int RW_BIT     = 15;
    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_e;

    // Reads carry a zero data byte so the slave never sees stale write data.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic              rw,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] wdata
    );
        return {rw, addr, (rw ? {DATA_W{1'b0}} : wdata)};
    endfunction

endpackage

// File: rtl/spi_sck_tick.sv
// Half-period timer: strobes half_end on the last clk cycle of every CLK_DIV-cycle window.
module spi_sck_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic half_end
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] cnt_r;

    assign half_end = (cnt_r == CNT_W'(CLK_DIV - 1));

    // Free-running modulo-CLK_DIV count, held at zero while the FSM is not framing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clear || half_end) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

endmodule

// File: rtl/spi_reg_master.sv
// SPI mode-0 master issuing 16-bit {rw, addr, data} register frames; captures the second byte.
module spi_reg_master
    import spi_reg_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_rw,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic              spi_sck,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic              spi_nss
);

    localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

    state_e                  state_r, state_s;
    // tx holds only the bits not yet placed on MOSI; bit 15 goes straight to spi_mosi.
    logic [FRAME_BITS-2:0]   tx_r, tx_s;
    // Only the last 8 captured bits matter, so rx keeps a byte.
    logic [DATA_W-1:0]       rx_r, rx_s;
    logic [3:0]              bit_cnt_r, bit_cnt_s;
    logic [GAP_W-1:0]        gap_cnt_r, gap_cnt_s;
    logic [FRAME_BITS-1:0]   frame_s;
    logic                    cmd_ready_s, rsp_valid_s, busy_s;
    logic                    sck_s, mosi_s, nss_s;
    logic [DATA_W-1:0]       rsp_rdata_s;
    logic                    half_end_s, tick_clear_s;

    assign frame_s      = build_frame(cmd_rw, cmd_addr, cmd_wdata);
    assign tick_clear_s = (state_r == ST_IDLE) || (state_r == ST_GAP);

    spi_sck_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk      (clk),
        .rst      (rst),
        .clear    (tick_clear_s),
        .half_end (half_end_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state, shift-register and next-output decisions.
    always_comb begin
        state_s     = state_r;
        tx_s        = tx_r;
        rx_s        = rx_r;
        bit_cnt_s   = bit_cnt_r;
        gap_cnt_s   = gap_cnt_r;
        cmd_ready_s = cmd_ready;
        rsp_valid_s = 1'b0;
        rsp_rdata_s = rsp_rdata;
        busy_s      = busy;
        sck_s       = spi_sck;
        mosi_s      = spi_mosi;
        nss_s       = spi_nss;

        case (state_r)
            ST_IDLE: begin
                cmd_ready_s = 1'b1;
                if (cmd_valid && cmd_ready) begin
                    tx_s        = frame_s[FRAME_BITS-2:0];
                    mosi_s      = frame_s[RW_BIT];
                    rx_s        = {DATA_W{1'b0}};
                    bit_cnt_s   = 4'd0;
                    cmd_ready_s = 1'b0;
                    busy_s      = 1'b1;
                    nss_s       = 1'b0;
                    sck_s       = 1'b0;
                    state_s     = ST_SETUP;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_SETUP: begin
                if (half_end_s) begin
                    sck_s   = 1'b1;
                    state_s = ST_SHIFT;
                end else begin
                    state_s = ST_SETUP;
                end
            end

            ST_SHIFT: begin
                if (half_end_s) begin
                    if (spi_sck) begin
                        // Last cycle of the high phase: capture MISO, then fall.
                        rx_s  = {rx_r[DATA_W-2:0], spi_miso};
                        sck_s = 1'b0;
                        if (bit_cnt_r != 4'd15) begin
                            mosi_s = tx_r[FRAME_BITS-2];
                            tx_s   = {tx_r[FRAME_BITS-3:0], 1'b0};
                        end else begin
                            tx_s = tx_r;
                        end
                    end else begin
                        if (bit_cnt_r == 4'd15) begin
                            state_s = ST_HOLD;
                        end else begin
                            bit_cnt_s = bit_cnt_r + 4'd1;
                            sck_s     = 1'b1;
                        end
                    end
                end else begin
                    state_s = ST_SHIFT;
                end
            end

            ST_HOLD: begin
                if (half_end_s) begin
                    nss_s       = 1'b1;
                    mosi_s      = 1'b0;
                    rsp_valid_s = 1'b1;
                    rsp_rdata_s = rx_r;
                    gap_cnt_s   = {GAP_W{1'b0}};
                    state_s     = ST_GAP;
                end else begin
                    state_s = ST_HOLD;
                end
            end

            ST_GAP: begin
                if (gap_cnt_r == GAP_W'(CS_GAP - 1)) begin
                    cmd_ready_s = 1'b1;
                    busy_s      = 1'b0;
                    state_s     = ST_IDLE;
                end else begin
                    gap_cnt_s = gap_cnt_r + GAP_W'(1);
                end
            end

            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Datapath registers and every block output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_r      <= {(FRAME_BITS-1){1'b0}};
            rx_r      <= {DATA_W{1'b0}};
            bit_cnt_r <= 4'd0;
            gap_cnt_r <= {GAP_W{1'b0}};
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= {DATA_W{1'b0}};
            busy      <= 1'b0;
            spi_sck   <= 1'b0;
            spi_mosi  <= 1'b0;
            spi_nss   <= 1'b1;
        end else begin
            tx_r      <= tx_s;
            rx_r      <= rx_s;
            bit_cnt_r <= bit_cnt_s;
            gap_cnt_r <= gap_cnt_s;
            cmd_ready <= cmd_ready_s;
            rsp_valid <= rsp_valid_s;
            rsp_rdata <= rsp_rdata_s;
            busy      <= busy_s;
            spi_sck   <= sck_s;
            spi_mosi  <= mosi_s;
            spi_nss   <= nss_s;
        end
    end

endmodule
